// File: rtl/axi_spi_scratchpad.sv
// axi_spi_scratchpad
//   Word-wide AXI4 slave scratchpad memory that sits behind the SPI slave's
//   AXI master. It serves one transaction at a time: a write burst followed by
//   its response, or a read burst.
//
// Ports
//   axi_aclk, axi_aresetn    : clock and synchronous active-low reset
//   axi_slave_aw_* / w_* / b_*: write address, write data and write response
//   axi_slave_ar_* / r_*      : read address and read data
//   prot/region/lock/cache/qos/user inputs are accepted and ignored;
//   b_user and r_user are driven to zero.
module axi_spi_scratchpad #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_USER_WIDTH = 6,
  parameter int AXI_ID_WIDTH   = 3,
  parameter int MEM_DEPTH      = 256
) (
  input  logic                      axi_aclk,
  input  logic                      axi_aresetn,
  input  logic                      axi_slave_aw_valid,
  input  logic [AXI_ADDR_WIDTH-1:0] axi_slave_aw_addr,
  input  logic [7:0]                axi_slave_aw_len,
  input  logic [2:0]                axi_slave_aw_size,
  input  logic [1:0]                axi_slave_aw_burst,
  input  logic [AXI_ID_WIDTH-1:0]   axi_slave_aw_id,
  input  logic [2:0]                axi_slave_aw_prot,
  input  logic [3:0]                axi_slave_aw_region,
  input  logic                      axi_slave_aw_lock,
  input  logic [3:0]                axi_slave_aw_cache,
  input  logic [3:0]                axi_slave_aw_qos,
  input  logic [AXI_USER_WIDTH-1:0] axi_slave_aw_user,
  output logic                      axi_slave_aw_ready,
  input  logic                      axi_slave_w_valid,
  input  logic [AXI_DATA_WIDTH-1:0] axi_slave_w_data,
  input  logic [AXI_DATA_WIDTH/8-1:0] axi_slave_w_strb,
  input  logic                      axi_slave_w_last,
  input  logic [AXI_USER_WIDTH-1:0] axi_slave_w_user,
  output logic                      axi_slave_w_ready,
  output logic                      axi_slave_b_valid,
  output logic [1:0]                axi_slave_b_resp,
  output logic [AXI_ID_WIDTH-1:0]   axi_slave_b_id,
  output logic [AXI_USER_WIDTH-1:0] axi_slave_b_user,
  input  logic                      axi_slave_b_ready,
  input  logic                      axi_slave_ar_valid,
  input  logic [AXI_ADDR_WIDTH-1:0] axi_slave_ar_addr,
  input  logic [7:0]                axi_slave_ar_len,
  input  logic [2:0]                axi_slave_ar_size,
  input  logic [1:0]                axi_slave_ar_burst,
  input  logic [AXI_ID_WIDTH-1:0]   axi_slave_ar_id,
  input  logic [2:0]                axi_slave_ar_prot,
  input  logic [3:0]                axi_slave_ar_region,
  input  logic                      axi_slave_ar_lock,
  input  logic [3:0]                axi_slave_ar_cache,
  input  logic [3:0]                axi_slave_ar_qos,
  input  logic [AXI_USER_WIDTH-1:0] axi_slave_ar_user,
  output logic                      axi_slave_ar_ready,
  output logic                      axi_slave_r_valid,
  output logic [AXI_DATA_WIDTH-1:0] axi_slave_r_data,
  output logic [1:0]                axi_slave_r_resp,
  output logic                      axi_slave_r_last,
  output logic [AXI_ID_WIDTH-1:0]   axi_slave_r_id,
  output logic [AXI_USER_WIDTH-1:0] axi_slave_r_user,
  input  logic                      axi_slave_r_ready
);

  localparam int BYTES = AXI_DATA_WIDTH / 8;
  localparam int OFF   = $clog2(BYTES);
  localparam int IDX   = $clog2(MEM_DEPTH);
  localparam logic [2:0]     SIZE_OK = 3'(OFF);
  localparam logic [IDX-1:0] IDX_MAX = IDX'(MEM_DEPTH - 1);
  localparam logic [1:0]     OKAY    = 2'b00;
  localparam logic [1:0]     SLVERR  = 2'b10;
  localparam logic [1:0]     INCR    = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_WRESP = 2'd2,
    S_READ  = 2'd3
  } state_t;

  // Bursts other than FIXED/INCR, narrow beats and addresses beyond the array are refused.
  function automatic logic addr_err(input logic [AXI_ADDR_WIDTH-1:0] addr,
                                    input logic [2:0] size, input logic [1:0] burst);
    return burst[1] | (size != SIZE_OK) | (|addr[AXI_ADDR_WIDTH-1:OFF+IDX]);
  endfunction

  logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

  state_t                    state_q, state_d;
  logic                      rd_prio_q, rd_prio_d;
  logic [AXI_ID_WIDTH-1:0]   id_q, id_d;
  logic [IDX-1:0]            idx_q, idx_d;
  logic [7:0]                len_q, len_d, cnt_q, cnt_d;
  logic [1:0]                burst_q, burst_d;
  logic                      err_q, err_d;
  logic                      aw_ready_q, aw_ready_d, ar_ready_q, ar_ready_d, w_ready_q, w_ready_d;
  logic                      b_valid_q, b_valid_d;
  logic [1:0]                b_resp_q, b_resp_d, r_resp_q, r_resp_d;
  logic [AXI_ID_WIDTH-1:0]   b_id_q, b_id_d, r_id_q, r_id_d;
  logic                      r_valid_q, r_valid_d, r_last_q, r_last_d;
  logic [AXI_DATA_WIDTH-1:0] r_data_q, r_data_d;

  logic           mem_we, aw_err, ar_err, wrap, beat_last, last_bad;
  logic [IDX-1:0] aw_idx, ar_idx, idx_nxt;

  assign aw_idx    = axi_slave_aw_addr[OFF +: IDX];
  assign ar_idx    = axi_slave_ar_addr[OFF +: IDX];
  assign aw_err    = addr_err(axi_slave_aw_addr, axi_slave_aw_size, axi_slave_aw_burst);
  assign ar_err    = addr_err(axi_slave_ar_addr, axi_slave_ar_size, axi_slave_ar_burst);
  assign idx_nxt   = (burst_q == INCR) ? idx_q + {{(IDX-1){1'b0}}, 1'b1} : idx_q;
  // An INCR burst stepping past the last word would silently wrap to word 0.
  assign wrap      = (burst_q == INCR) && (idx_q == IDX_MAX);
  assign beat_last = (cnt_q == len_q);
  assign last_bad  = (axi_slave_w_last != beat_last);

  // Next-state and next-output computation for the transaction FSM.
  always_comb begin
    state_d = state_q;   rd_prio_d = rd_prio_q; id_d = id_q;       idx_d = idx_q;
    len_d = len_q;       burst_d = burst_q;     cnt_d = cnt_q;     err_d = err_q;
    aw_ready_d = 1'b0;   ar_ready_d = 1'b0;     w_ready_d = w_ready_q;
    b_valid_d = b_valid_q; b_resp_d = b_resp_q; b_id_d = b_id_q;
    r_valid_d = r_valid_q; r_data_d = r_data_q; r_resp_d = r_resp_q;
    r_last_d = r_last_q; r_id_d = r_id_q;       mem_we = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (aw_ready_q && axi_slave_aw_valid) begin
          id_d = axi_slave_aw_id;   idx_d = aw_idx;  len_d = axi_slave_aw_len;
          burst_d = axi_slave_aw_burst; cnt_d = 8'd0; err_d = aw_err;
          w_ready_d = 1'b1;
          state_d = S_WRITE;
        end else if (ar_ready_q && axi_slave_ar_valid) begin
          id_d = axi_slave_ar_id;   idx_d = ar_idx;  len_d = axi_slave_ar_len;
          burst_d = axi_slave_ar_burst; cnt_d = 8'd0; err_d = ar_err;
          // First beat is loaded straight from the AR fields so r_valid rises next cycle.
          r_valid_d = 1'b1;
          r_id_d    = axi_slave_ar_id;
          r_last_d  = (axi_slave_ar_len == 8'd0);
          r_resp_d  = ar_err ? SLVERR : OKAY;
          r_data_d  = ar_err ? {AXI_DATA_WIDTH{1'b0}} : mem[ar_idx];
          state_d   = S_READ;
        end else begin
          // Ready is raised one cycle after the grant; the priority pointer only
          // flips when both channels actually contend.
          aw_ready_d = axi_slave_aw_valid && (!axi_slave_ar_valid || !rd_prio_q);
          ar_ready_d = axi_slave_ar_valid && (!axi_slave_aw_valid || rd_prio_q);
          if (axi_slave_aw_valid && axi_slave_ar_valid) begin
            rd_prio_d = ~rd_prio_q;
          end else begin
            rd_prio_d = rd_prio_q;
          end
        end
      end
      S_WRITE: begin
        if (axi_slave_w_valid) begin
          mem_we = ~err_q;
          if (beat_last) begin
            err_d     = err_q | last_bad;
            w_ready_d = 1'b0;
            b_valid_d = 1'b1;
            b_id_d    = id_q;
            b_resp_d  = (err_q | last_bad) ? SLVERR : OKAY;
            state_d   = S_WRESP;
          end else begin
            err_d = err_q | last_bad | wrap;
            cnt_d = cnt_q + 8'd1;
            idx_d = idx_nxt;
          end
        end else begin
          mem_we = 1'b0;
        end
      end
      S_WRESP: begin
        if (axi_slave_b_ready) begin
          b_valid_d = 1'b0;
          state_d   = S_IDLE;
        end else begin
          b_valid_d = 1'b1;
        end
      end
      S_READ: begin
        if (axi_slave_r_ready) begin
          if (r_last_q) begin
            r_valid_d = 1'b0;
            r_last_d  = 1'b0;
            state_d   = S_IDLE;
          end else begin
            cnt_d    = cnt_q + 8'd1;
            idx_d    = idx_nxt;
            err_d    = err_q | wrap;
            r_last_d = ((cnt_q + 8'd1) == len_q);
            r_resp_d = (err_q | wrap) ? SLVERR : OKAY;
            r_data_d = (err_q | wrap) ? {AXI_DATA_WIDTH{1'b0}} : mem[idx_nxt];
          end
        end else begin
          r_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      state_q <= S_IDLE;  rd_prio_q <= 1'b0;  id_q <= {AXI_ID_WIDTH{1'b0}};
      idx_q <= {IDX{1'b0}}; len_q <= 8'd0;    burst_q <= 2'b00;  cnt_q <= 8'd0;
      err_q <= 1'b0;      aw_ready_q <= 1'b0; ar_ready_q <= 1'b0; w_ready_q <= 1'b0;
      b_valid_q <= 1'b0;  b_resp_q <= 2'b00;  b_id_q <= {AXI_ID_WIDTH{1'b0}};
      r_valid_q <= 1'b0;  r_data_q <= {AXI_DATA_WIDTH{1'b0}}; r_resp_q <= 2'b00;
      r_last_q <= 1'b0;   r_id_q <= {AXI_ID_WIDTH{1'b0}};
    end else begin
      state_q <= state_d; rd_prio_q <= rd_prio_d; id_q <= id_d;
      idx_q <= idx_d;     len_q <= len_d;      burst_q <= burst_d; cnt_q <= cnt_d;
      err_q <= err_d;     aw_ready_q <= aw_ready_d; ar_ready_q <= ar_ready_d; w_ready_q <= w_ready_d;
      b_valid_q <= b_valid_d; b_resp_q <= b_resp_d; b_id_q <= b_id_d;
      r_valid_q <= r_valid_d; r_data_q <= r_data_d; r_resp_q <= r_resp_d;
      r_last_q <= r_last_d;   r_id_q <= r_id_d;
    end
  end

  // Byte-enabled storage write; contents survive reset, but a beat on a reset edge is dropped.
  always_ff @(posedge axi_aclk) begin
    if (axi_aresetn && mem_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (axi_slave_w_strb[b]) begin
          mem[idx_q][b*8 +: 8] <= axi_slave_w_data[b*8 +: 8];
        end
      end
    end
  end

  assign axi_slave_aw_ready = aw_ready_q;
  assign axi_slave_ar_ready = ar_ready_q;
  assign axi_slave_w_ready  = w_ready_q;
  assign axi_slave_b_valid  = b_valid_q;
  assign axi_slave_b_resp   = b_resp_q;
  assign axi_slave_b_id     = b_id_q;
  assign axi_slave_b_user   = {AXI_USER_WIDTH{1'b0}};
  assign axi_slave_r_valid  = r_valid_q;
  assign axi_slave_r_data   = r_data_q;
  assign axi_slave_r_resp   = r_resp_q;
  assign axi_slave_r_last   = r_last_q;
  assign axi_slave_r_id     = r_id_q;
  assign axi_slave_r_user   = {AXI_USER_WIDTH{1'b0}};

  logic unused_inputs;
  assign unused_inputs = ^{axi_slave_aw_prot, axi_slave_aw_region, axi_slave_aw_lock,
                           axi_slave_aw_cache, axi_slave_aw_qos, axi_slave_aw_user,
                           axi_slave_ar_prot, axi_slave_ar_region, axi_slave_ar_lock,
                           axi_slave_ar_cache, axi_slave_ar_qos, axi_slave_ar_user,
                           axi_slave_w_user, axi_slave_aw_addr[OFF-1:0], axi_slave_ar_addr[OFF-1:0]};

endmodule

// File: tb/tb_axi_spi_scratchpad.sv
// tb_axi_spi_scratchpad
//   Directed bench for axi_spi_scratchpad: INCR write/read, byte strobes,
//   AW/AR arbitration, out-of-range access, read back-pressure and reset
//   in the middle of a write burst. Expected values are written out by hand.
module tb_axi_spi_scratchpad;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        aw_valid, aw_ready, ar_valid, ar_ready;
  logic [31:0] aw_addr, ar_addr;
  logic [7:0]  aw_len, ar_len;
  logic [2:0]  aw_size, ar_size, aw_id, ar_id;
  logic [1:0]  aw_burst, ar_burst;
  logic        w_valid, w_last, w_ready;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic        b_valid, b_ready;
  logic [1:0]  b_resp;
  logic [2:0]  b_id;
  logic [5:0]  b_user, r_user;
  logic        r_valid, r_ready, r_last;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic [2:0]  r_id;
  logic [2:0]  zero3 = 3'd0;
  logic [3:0]  zero4 = 4'd0;
  logic [5:0]  zero6 = 6'd0;
  logic        zero1 = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;
  int nb;

  logic [63:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  logic [2:0]  rd_id   [16];

  axi_spi_scratchpad dut (
    .axi_aclk(clk), .axi_aresetn(aresetn),
    .axi_slave_aw_valid(aw_valid), .axi_slave_aw_addr(aw_addr), .axi_slave_aw_len(aw_len),
    .axi_slave_aw_size(aw_size), .axi_slave_aw_burst(aw_burst), .axi_slave_aw_id(aw_id),
    .axi_slave_aw_prot(zero3), .axi_slave_aw_region(zero4), .axi_slave_aw_lock(zero1),
    .axi_slave_aw_cache(zero4), .axi_slave_aw_qos(zero4), .axi_slave_aw_user(zero6),
    .axi_slave_aw_ready(aw_ready),
    .axi_slave_w_valid(w_valid), .axi_slave_w_data(w_data), .axi_slave_w_strb(w_strb),
    .axi_slave_w_last(w_last), .axi_slave_w_user(zero6), .axi_slave_w_ready(w_ready),
    .axi_slave_b_valid(b_valid), .axi_slave_b_resp(b_resp), .axi_slave_b_id(b_id),
    .axi_slave_b_user(b_user), .axi_slave_b_ready(b_ready),
    .axi_slave_ar_valid(ar_valid), .axi_slave_ar_addr(ar_addr), .axi_slave_ar_len(ar_len),
    .axi_slave_ar_size(ar_size), .axi_slave_ar_burst(ar_burst), .axi_slave_ar_id(ar_id),
    .axi_slave_ar_prot(zero3), .axi_slave_ar_region(zero4), .axi_slave_ar_lock(zero1),
    .axi_slave_ar_cache(zero4), .axi_slave_ar_qos(zero4), .axi_slave_ar_user(zero6),
    .axi_slave_ar_ready(ar_ready),
    .axi_slave_r_valid(r_valid), .axi_slave_r_data(r_data), .axi_slave_r_resp(r_resp),
    .axi_slave_r_last(r_last), .axi_slave_r_id(r_id), .axi_slave_r_user(r_user),
    .axi_slave_r_ready(r_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic aw_req(input logic [31:0] a, input logic [7:0] l, input logic [1:0] bu, input logic [2:0] id);
    aw_addr = a; aw_len = l; aw_burst = bu; aw_size = 3'd3; aw_id = id; aw_valid = 1'b1;
  endtask

  task automatic ar_req(input logic [31:0] a, input logic [7:0] l, input logic [1:0] bu, input logic [2:0] id);
    ar_addr = a; ar_len = l; ar_burst = bu; ar_size = 3'd3; ar_id = id; ar_valid = 1'b1;
  endtask

  task automatic aw_wait();
    int n = 0;
    while (!aw_ready && n < 20) begin @(negedge clk); n++; end
    chk(aw_ready, 1'b1, "aw_ready");
    @(posedge clk); #1;
    aw_valid = 1'b0;
  endtask

  task automatic ar_wait();
    int n = 0;
    while (!ar_ready && n < 20) begin @(negedge clk); n++; end
    chk(ar_ready, 1'b1, "ar_ready");
    @(posedge clk); #1;
    ar_valid = 1'b0;
    chk(r_valid, 1'b1, "r_valid_rise");
  endtask

  task automatic w_beat(input logic [63:0] d, input logic [7:0] s, input logic l);
    int n = 0;
    w_data = d; w_strb = s; w_last = l; w_valid = 1'b1;
    while (!w_ready && n < 20) begin @(negedge clk); n++; end
    chk(w_ready, 1'b1, "w_ready");
    @(posedge clk); #1;
    w_valid = 1'b0; w_last = 1'b0;
  endtask

  task automatic b_take(input logic [1:0] er, input logic [2:0] eid);
    int n = 0;
    b_ready = 1'b1;
    while (!b_valid && n < 20) begin @(negedge clk); n++; end
    chk(b_valid, 1'b1, "b_valid");
    chk(b_resp, er, "b_resp");
    chk(b_id, eid, "b_id");
    @(posedge clk); #1;
    b_ready = 1'b0;
  endtask

  // Collects beats until r_last; with tog set, r_ready alternates 1/0 and
  // stalled beats must keep their data.
  task automatic r_collect(input bit tog, output int cnt);
    int k = 0;
    bit done = 1'b0, stalled = 1'b0;
    logic [63:0] held = 64'd0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      r_ready = tog ? (c % 2 == 0) : 1'b1;
      if (r_valid) begin
        if (stalled) chk(r_data, held, "r_stall_data");
        if (r_ready) begin
          if (k < 16) begin
            rd_data[k] = r_data; rd_resp[k] = r_resp; rd_last[k] = r_last; rd_id[k] = r_id;
          end
          k++;
          stalled = 1'b0;
          if (r_last) done = 1'b1;
        end else begin
          stalled = 1'b1;
          held = r_data;
        end
      end
    end
    chk(done, 1'b1, "r_done");
    @(negedge clk);
    r_ready = 1'b0;
    chk(r_valid, 1'b0, "r_valid_drop");
    cnt = k;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({aw_ready, ar_ready, w_ready, b_valid, r_valid, r_last}, 64'd0, {tag, "_hs"});
    chk({b_resp, r_resp, b_id, r_id}, 64'd0, {tag, "_resp_id"});
    chk(r_data, 64'd0, {tag, "_rdata"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    aresetn = 1'b0; aw_valid = 1'b0; ar_valid = 1'b0; w_valid = 1'b0; b_ready = 1'b0;
    r_ready = 1'b0; aw_addr = 32'd0; ar_addr = 32'd0; aw_len = 8'd0; ar_len = 8'd0;
    aw_size = 3'd3; ar_size = 3'd3; aw_burst = 2'b01; ar_burst = 2'b01; aw_id = 3'd0;
    ar_id = 3'd0; w_data = 64'd0; w_strb = 8'd0; w_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    aresetn = 1'b1;
    @(negedge clk);

    // INCR write of four beats at 0x10, then read back.
    aw_req(32'h10, 8'd3, 2'b01, 3'd5); aw_wait();
    w_beat(64'h11, 8'hFF, 1'b0); w_beat(64'h22, 8'hFF, 1'b0);
    w_beat(64'h33, 8'hFF, 1'b0); w_beat(64'h44, 8'hFF, 1'b1);
    b_take(2'b00, 3'd5);
    ar_req(32'h10, 8'd3, 2'b01, 3'd2); ar_wait(); r_collect(1'b0, nb);
    chk(64'(nb), 64'd4, "incr_nbeats");
    for (int k = 0; k < 4; k++) begin
      chk(rd_data[k], 64'(k + 1) * 64'h11, "incr_data");
      chk({rd_resp[k], rd_last[k], rd_id[k]}, {2'b00, (k == 3), 3'd2}, "incr_resp_last_id");
    end

    // Byte strobes: upper half kept, lower half cleared.
    aw_req(32'h40, 8'd0, 2'b01, 3'd1); aw_wait(); w_beat(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1);
    b_take(2'b00, 3'd1);
    aw_req(32'h40, 8'd0, 2'b01, 3'd1); aw_wait(); w_beat(64'd0, 8'h0F, 1'b1);
    b_take(2'b00, 3'd1);
    ar_req(32'h40, 8'd0, 2'b01, 3'd0); ar_wait(); r_collect(1'b0, nb);
    chk(rd_data[0], 64'hFFFF_FFFF_0000_0000, "strobe_data");

    // Contention 1: write wins, then the waiting read sees the new data.
    aw_req(32'h80, 8'd0, 2'b01, 3'd1); ar_req(32'h80, 8'd0, 2'b01, 3'd4);
    @(posedge clk); @(negedge clk);
    chk({aw_ready, ar_ready}, 2'b10, "arb1_grant");
    aw_wait(); w_beat(64'hCAFE_F00D_1234_5678, 8'hFF, 1'b1); b_take(2'b00, 3'd1);
    ar_wait(); r_collect(1'b0, nb);
    chk(rd_data[0], 64'hCAFE_F00D_1234_5678, "arb1_rdata");
    chk({rd_id[0], rd_last[0]}, {3'd4, 1'b1}, "arb1_rid_last");

    // Contention 2: read wins this time.
    aw_req(32'h88, 8'd0, 2'b01, 3'd3); ar_req(32'h80, 8'd0, 2'b01, 3'd6);
    @(posedge clk); @(negedge clk);
    chk({aw_ready, ar_ready}, 2'b01, "arb2_grant");
    ar_wait(); r_collect(1'b0, nb);
    chk(rd_data[0], 64'hCAFE_F00D_1234_5678, "arb2_rdata");
    aw_wait(); w_beat(64'hBEEF, 8'hFF, 1'b1); b_take(2'b00, 3'd3);
    ar_req(32'h88, 8'd0, 2'b01, 3'd0); ar_wait(); r_collect(1'b0, nb);
    chk(rd_data[0], 64'hBEEF, "arb2_wdata");

    // Out-of-range word index 256 aliases word 0 in the low bits but must not touch it.
    aw_req(32'h0, 8'd0, 2'b01, 3'd2); aw_wait(); w_beat(64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1);
    b_take(2'b00, 3'd2);
    aw_req(32'h800, 8'd0, 2'b01, 3'd2); aw_wait(); w_beat(64'hDEAD_DEAD_DEAD_DEAD, 8'hFF, 1'b1);
    b_take(2'b10, 3'd2);
    ar_req(32'h0, 8'd0, 2'b01, 3'd0); ar_wait(); r_collect(1'b0, nb);
    chk({rd_data[0], rd_resp[0]}, {64'h0123_4567_89AB_CDEF, 2'b00}, "oor_mem_kept");
    ar_req(32'h800, 8'd0, 2'b01, 3'd0); ar_wait(); r_collect(1'b0, nb);
    chk({rd_data[0], rd_resp[0], rd_last[0]}, {64'd0, 2'b10, 1'b1}, "oor_read");

    // Eight-beat read with r_ready toggling.
    aw_req(32'h100, 8'd7, 2'b01, 3'd0); aw_wait();
    for (int k = 0; k < 8; k++) w_beat(64'h0101_0101_0101_0101 * 64'(k + 1), 8'hFF, (k == 7));
    b_take(2'b00, 3'd0);
    ar_req(32'h100, 8'd7, 2'b01, 3'd3); ar_wait(); r_collect(1'b1, nb);
    chk(64'(nb), 64'd8, "stall_nbeats");
    for (int k = 0; k < 8; k++) begin
      chk(rd_data[k], 64'h0101_0101_0101_0101 * 64'(k + 1), "stall_data");
      chk({rd_resp[k], rd_last[k]}, {2'b00, (k == 7)}, "stall_resp_last");
    end

    // Reset during beat 2 of a four-beat write.
    aw_req(32'h208, 8'd0, 2'b01, 3'd0); aw_wait(); w_beat(64'h5555_5555_5555_5555, 8'hFF, 1'b1);
    b_take(2'b00, 3'd0);
    aw_req(32'h200, 8'd3, 2'b01, 3'd7); aw_wait(); w_beat(64'hA1A1_A1A1_A1A1_A1A1, 8'hFF, 1'b0);
    w_data = 64'hA2A2_A2A2_A2A2_A2A2; w_strb = 8'hFF; w_last = 1'b0; w_valid = 1'b1;
    aresetn = 1'b0;
    @(posedge clk); #1;
    w_valid = 1'b0;
    @(negedge clk);
    chk_all_zero("midreset");
    aresetn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk(b_valid, 1'b0, "midreset_no_b");
    end
    ar_req(32'h200, 8'd1, 2'b01, 3'd0); ar_wait(); r_collect(1'b0, nb);
    chk(rd_data[0], 64'hA1A1_A1A1_A1A1_A1A1, "midreset_beat1_kept");
    chk(rd_data[1], 64'h5555_5555_5555_5555, "midreset_beat2_dropped");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
